// File: rtl/ac_motor_gate_decoder_if.sv
// Gate/telemetry bus of the AC motor gate decoder: six gate inputs and controls in,
// decoded vector, sector, dwell times, revolution period and fault flags out.
interface ac_motor_gate_decoder_if;
  logic        enable;
  logic [7:0]  min_delay;
  logic        s1_high, s1_low, s2_high, s2_low, s3_high, s3_low;
  logic [2:0]  vec;
  logic        vec_valid;
  logic [2:0]  sector;
  logic        sector_valid;
  logic [14:0] t_zero, t_first, t_second;
  logic        cycle_strobe;
  logic [23:0] rev_period;
  logic        rev_strobe;
  logic        short_error, short_fault, dead_error;

  modport master (
    output enable, min_delay, s1_high, s1_low, s2_high, s2_low, s3_high, s3_low,
    input  vec, vec_valid, sector, sector_valid, t_zero, t_first, t_second,
           cycle_strobe, rev_period, rev_strobe, short_error, short_fault, dead_error
  );

  modport slave (
    input  enable, min_delay, s1_high, s1_low, s2_high, s2_low, s3_high, s3_low,
    output vec, vec_valid, sector, sector_valid, t_zero, t_first, t_second,
           cycle_strobe, rev_period, rev_strobe, short_error, short_fault, dead_error
  );
endinterface

// File: rtl/ac_motor_gate_decoder.sv
// Gate-side decoder: space vector, sector, dwell times, revolution period, shoot-through and dead-time
// monitoring; vec 2 cycles, strobes 3 cycles after the gates; no backpressure. AC_MOTOR_GATE_DECODER_DEADTIME_CHECK_EN adds the dead-time check.
module ac_motor_gate_decoder (
  input  logic                   clk,
  input  logic                   reset,
  ac_motor_gate_decoder_if.slave bus
);

  localparam logic [14:0] DWELL_MAX = 15'h7fff;
  localparam logic [23:0] REV_MAX   = 24'hff_ffff;

  function automatic logic [2:0] vec_enc(input logic [2:0] lvl);
    case (lvl)
      3'b000:  vec_enc = 3'd0;
      3'b100:  vec_enc = 3'd1;
      3'b110:  vec_enc = 3'd2;
      3'b010:  vec_enc = 3'd3;
      3'b011:  vec_enc = 3'd4;
      3'b001:  vec_enc = 3'd5;
      3'b101:  vec_enc = 3'd6;
      default: vec_enc = 3'd7;
    endcase
  endfunction

  function automatic logic [14:0] dwell_inc(input logic [14:0] c);
    return (c == DWELL_MAX) ? c : c + 15'd1;
  endfunction

  // Bit 2 is phase 1, bit 0 is phase 3 throughout.
  logic [2:0] hi_q, lo_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= {bus.s1_high, bus.s2_high, bus.s3_high};
      lo_q <= {bus.s1_low,  bus.s2_low,  bus.s3_low};
    end
  end

  logic [2:0] defd, shrt, lvl_d, lvl_q;
  assign defd  = hi_q ^ lo_q;
  assign shrt  = hi_q & lo_q;
  assign lvl_d = (defd & hi_q) | (~defd & lvl_q);

  logic [2:0] vec_q;
  logic       vec_valid_q, short_error_q, short_fault_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q         <= '0;
      vec_q         <= '0;
      vec_valid_q   <= 1'b0;
      short_error_q <= 1'b0;
      short_fault_q <= 1'b0;
    end else begin
      lvl_q         <= lvl_d;
      vec_q         <= vec_enc(lvl_d);
      vec_valid_q   <= &defd;
      short_error_q <= bus.enable && (|shrt);
      if (bus.enable && (|shrt)) short_fault_q <= 1'b1;
    end
  end

  logic [14:0] zero_cnt_q, zero_cnt_d, a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [2:0]  a_vec_q, a_vec_d, b_vec_q, b_vec_d;
  logic        a_set_q, a_set_d, b_set_q, b_set_d, last_nz_q, last_nz_d;
  logic [23:0] rev_cnt_q, rev_cnt_d, rev_period_q, rev_period_d;
  logic        armed_q, armed_d;
  logic [14:0] t_zero_q, t_zero_d, t_first_q, t_first_d, t_second_q, t_second_d;
  logic [2:0]  sector_q, sector_d;
  logic        sector_valid_q, sector_valid_d;
  logic        cycle_strobe_q, cycle_strobe_d, rev_strobe_q, rev_strobe_d;

  logic [2:0] pair_lo, pair_hi, pair_sector;
  logic       pair_adj, boundary, wrap;
  always_comb begin
    pair_lo     = (a_vec_q < b_vec_q) ? a_vec_q : b_vec_q;
    pair_hi     = (a_vec_q < b_vec_q) ? b_vec_q : a_vec_q;
    pair_sector = (pair_lo == 3'd1 && pair_hi == 3'd6) ? 3'd5 : pair_lo - 3'd1;
    pair_adj    = a_set_q && b_set_q &&
                  ((pair_hi == pair_lo + 3'd1) || (pair_lo == 3'd1 && pair_hi == 3'd6));
  end

  assign boundary = bus.enable && vec_valid_q && (vec_q == 3'd0) && last_nz_q;
  assign wrap     = boundary && pair_adj && (pair_sector == 3'd0) &&
                    sector_valid_q && (sector_q == 3'd5);

  always_comb begin
    zero_cnt_d     = zero_cnt_q;
    a_cnt_d        = a_cnt_q;
    b_cnt_d        = b_cnt_q;
    a_vec_d        = a_vec_q;
    b_vec_d        = b_vec_q;
    a_set_d        = a_set_q;
    b_set_d        = b_set_q;
    last_nz_d      = last_nz_q;
    rev_cnt_d      = rev_cnt_q;
    armed_d        = armed_q;
    t_zero_d       = t_zero_q;
    t_first_d      = t_first_q;
    t_second_d     = t_second_q;
    sector_d       = sector_q;
    sector_valid_d = sector_valid_q;
    rev_period_d   = rev_period_q;
    cycle_strobe_d = 1'b0;
    rev_strobe_d   = 1'b0;
    if (!bus.enable) begin
      zero_cnt_d = '0;
      a_cnt_d    = '0;
      b_cnt_d    = '0;
      a_set_d    = 1'b0;
      b_set_d    = 1'b0;
      last_nz_d  = 1'b0;
      rev_cnt_d  = '0;
      armed_d    = 1'b0;
    end else begin
      rev_cnt_d = (rev_cnt_q == REV_MAX) ? rev_cnt_q : rev_cnt_q + 24'd1;
      if (vec_valid_q) last_nz_d = (vec_q != 3'd0);
      if (boundary) begin
        t_zero_d       = zero_cnt_q;
        t_first_d      = a_cnt_q;
        t_second_d     = b_cnt_q;
        cycle_strobe_d = 1'b1;
        zero_cnt_d     = 15'd1;
        a_cnt_d        = '0;
        b_cnt_d        = '0;
        a_set_d        = 1'b0;
        b_set_d        = 1'b0;
        sector_valid_d = pair_adj;
        if (pair_adj) sector_d = pair_sector;
        // The wrap cycle itself is the first counted cycle of the next revolution.
        if (wrap) begin
          if (armed_q) begin
            rev_period_d = rev_cnt_q;
            rev_strobe_d = 1'b1;
          end
          armed_d   = 1'b1;
          rev_cnt_d = 24'd1;
        end
      end else if (vec_valid_q) begin
        if (vec_q == 3'd0 || vec_q == 3'd7) begin
          zero_cnt_d = dwell_inc(zero_cnt_q);
        end else if (!a_set_q) begin
          a_set_d = 1'b1;
          a_vec_d = vec_q;
          a_cnt_d = dwell_inc(a_cnt_q);
        end else if (vec_q == a_vec_q) begin
          a_cnt_d = dwell_inc(a_cnt_q);
        end else begin
          if (!b_set_q) begin
            b_set_d = 1'b1;
            b_vec_d = vec_q;
          end
          b_cnt_d = dwell_inc(b_cnt_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_cnt_q     <= '0;
      a_cnt_q        <= '0;
      b_cnt_q        <= '0;
      a_vec_q        <= '0;
      b_vec_q        <= '0;
      a_set_q        <= 1'b0;
      b_set_q        <= 1'b0;
      last_nz_q      <= 1'b0;
      rev_cnt_q      <= '0;
      armed_q        <= 1'b0;
      t_zero_q       <= '0;
      t_first_q      <= '0;
      t_second_q     <= '0;
      sector_q       <= '0;
      sector_valid_q <= 1'b0;
      rev_period_q   <= '0;
      cycle_strobe_q <= 1'b0;
      rev_strobe_q   <= 1'b0;
    end else begin
      zero_cnt_q     <= zero_cnt_d;
      a_cnt_q        <= a_cnt_d;
      b_cnt_q        <= b_cnt_d;
      a_vec_q        <= a_vec_d;
      b_vec_q        <= b_vec_d;
      a_set_q        <= a_set_d;
      b_set_q        <= b_set_d;
      last_nz_q      <= last_nz_d;
      rev_cnt_q      <= rev_cnt_d;
      armed_q        <= armed_d;
      t_zero_q       <= t_zero_d;
      t_first_q      <= t_first_d;
      t_second_q     <= t_second_d;
      sector_q       <= sector_d;
      sector_valid_q <= sector_valid_d;
      rev_period_q   <= rev_period_d;
      cycle_strobe_q <= cycle_strobe_d;
      rev_strobe_q   <= rev_strobe_d;
    end
  end

`ifdef AC_MOTOR_GATE_DECODER_DEADTIME_CHECK_EN
  // lvl_ok_q keeps the reset default level from being mistaken for a real previous level.
  logic [2:0][7:0] dead_cnt_q, dead_cnt_d;
  logic [2:0]      lvl_ok_q;
  logic            dead_hit, dead_error_q;
  always_comb begin
    dead_cnt_d = dead_cnt_q;
    dead_hit   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!defd[i] && !shrt[i]) begin
        if (dead_cnt_q[i] != 8'hff) dead_cnt_d[i] = dead_cnt_q[i] + 8'd1;
      end else if (defd[i]) begin
        if (lvl_ok_q[i] && (hi_q[i] != lvl_q[i]) && (dead_cnt_q[i] < bus.min_delay))
          dead_hit = 1'b1;
        dead_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dead_cnt_q   <= '0;
      lvl_ok_q     <= '0;
      dead_error_q <= 1'b0;
    end else begin
      lvl_ok_q <= lvl_ok_q | defd;
      if (!bus.enable) begin
        dead_cnt_q <= '0;
      end else begin
        dead_cnt_q <= dead_cnt_d;
        if (dead_hit) dead_error_q <= 1'b1;
      end
    end
  end
  assign bus.dead_error = dead_error_q;
`else
  logic unused_min_delay;
  assign unused_min_delay = ^bus.min_delay;
  assign bus.dead_error   = 1'b0;
`endif

  assign bus.vec          = vec_q;
  assign bus.vec_valid    = vec_valid_q;
  assign bus.sector       = sector_q;
  assign bus.sector_valid = sector_valid_q;
  assign bus.t_zero       = t_zero_q;
  assign bus.t_first      = t_first_q;
  assign bus.t_second     = t_second_q;
  assign bus.cycle_strobe = cycle_strobe_q;
  assign bus.rev_period   = rev_period_q;
  assign bus.rev_strobe   = rev_strobe_q;
  assign bus.short_error  = short_error_q;
  assign bus.short_fault  = short_fault_q;

endmodule

// File: tb/tb_ac_motor_gate_decoder.sv
// Directed bench for ac_motor_gate_decoder: vector decode, dwell, sector, revolution, fault flags.
module tb_ac_motor_gate_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [2:0] pat [8] = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b111};

  ac_motor_gate_decoder_if bus ();
  ac_motor_gate_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lv(input logic [2:0] b);
    bus.s1_high = b[2]; bus.s1_low = !b[2];
    bus.s2_high = b[1]; bus.s2_low = !b[1];
    bus.s3_high = b[0]; bus.s3_low = !b[0];
  endtask

  task automatic hold_lv(input logic [2:0] b, input int n);
    set_lv(b);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_lv(3'b000);
    repeat (4) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] r;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r = 6'($urandom);
      {bus.s1_high, bus.s1_low, bus.s2_high, bus.s2_low, bus.s3_high, bus.s3_low} = r;
      tick();
      total++;
      if ({bus.cycle_strobe, bus.rev_strobe} !== 2'b00) begin
        bad++; $display("FAIL reset_strobes got %b want 00", {bus.cycle_strobe, bus.rev_strobe});
      end
    end
    total++;
    if (bus.vec !== 3'd0 || bus.vec_valid !== 1'b0) begin
      bad++; $display("FAIL reset_vec got %0d/%b want 0/0", bus.vec, bus.vec_valid);
    end
    total++;
    if (bus.sector !== 3'd0 || bus.sector_valid !== 1'b0) begin
      bad++; $display("FAIL reset_sector got %0d/%b want 0/0", bus.sector, bus.sector_valid);
    end
    total++;
    if ({bus.t_zero, bus.t_first, bus.t_second} !== 45'd0) begin
      bad++; $display("FAIL reset_dwell got %0d/%0d/%0d want 0/0/0", bus.t_zero, bus.t_first, bus.t_second);
    end
    total++;
    if (bus.rev_period !== 24'd0) begin
      bad++; $display("FAIL reset_rev_period got %0d want 0", bus.rev_period);
    end
    total++;
    if ({bus.short_error, bus.short_fault, bus.dead_error} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got %b want 000", {bus.short_error, bus.short_fault, bus.dead_error});
    end
  endtask

  task automatic test_vec_decode();
    do_reset();
    hold_lv(3'b000, 3);
    for (int i = 0; i < 8; i++) begin
      set_lv(pat[i]);
      tick();
      if (i > 0) begin
        total++;
        if (bus.vec !== 3'(i - 1)) begin
          bad++; $display("FAIL vec_latency_%0d got %0d want %0d", i, bus.vec, i - 1);
        end
      end
      tick();
      total++;
      if (bus.vec !== 3'(i) || bus.vec_valid !== 1'b1) begin
        bad++; $display("FAIL vec_decode_%0d got %0d/%b want %0d/1", i, bus.vec, bus.vec_valid, i);
      end
    end
  endtask

  task automatic test_dwell();
    do_reset();
    hold_lv(3'b000, 10);
    hold_lv(3'b100, 20);
    hold_lv(3'b110, 30);
    hold_lv(3'b111, 10);
    set_lv(3'b000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (bus.cycle_strobe !== (k == 3)) begin
        bad++; $display("FAIL dwell_strobe_t%0d got %b want %b", k, bus.cycle_strobe, (k == 3));
      end
      if (k == 3) begin
        total++;
        if (bus.t_zero !== 15'd20 || bus.t_first !== 15'd20 || bus.t_second !== 15'd30) begin
          bad++; $display("FAIL dwell_times got %0d/%0d/%0d want 20/20/30", bus.t_zero, bus.t_first, bus.t_second);
        end
        total++;
        if (bus.sector !== 3'd0 || bus.sector_valid !== 1'b1) begin
          bad++; $display("FAIL dwell_sector got %0d/%b want 0/1", bus.sector, bus.sector_valid);
        end
      end
    end
  endtask

  task automatic test_revolution();
    int cyc = 0, revs = 0, misaligned = 0, s;
    logic [23:0] per = '0;
    logic [2:0]  a, b;
    do_reset();
    for (int p = 0; p < 13; p++) begin
      s = p % 6;
      a = pat[s + 1];
      b = pat[((s + 1) % 6) + 1];
      for (int c = 0; c < 100; c++) begin
        set_lv(c < 40 ? 3'b000 : (c < 70 ? a : b));
        tick();
        if (bus.cycle_strobe) cyc++;
        if (bus.rev_strobe) begin
          revs++;
          per = bus.rev_period;
          if (!bus.cycle_strobe) misaligned++;
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      set_lv(3'b000);
      tick();
      if (bus.cycle_strobe) cyc++;
      if (bus.rev_strobe) begin
        revs++;
        per = bus.rev_period;
        if (!bus.cycle_strobe) misaligned++;
      end
    end
    total++;
    if (cyc !== 13) begin bad++; $display("FAIL rev_cycle_strobes got %0d want 13", cyc); end
    total++;
    if (revs !== 1) begin bad++; $display("FAIL rev_strobe_count got %0d want 1", revs); end
    total++;
    if (per !== 24'd600) begin bad++; $display("FAIL rev_period got %0d want 600", per); end
    total++;
    if (misaligned !== 0) begin bad++; $display("FAIL rev_strobe_align got %0d want 0", misaligned); end
    total++;
    if (bus.sector !== 3'd0 || bus.sector_valid !== 1'b1) begin
      bad++; $display("FAIL rev_final_sector got %0d/%b want 0/1", bus.sector, bus.sector_valid);
    end
  endtask

  task automatic test_short();
    do_reset();
    hold_lv(3'b000, 5);
    bus.s2_high = 1'b1;
    tick();
    total++;
    if (bus.short_error !== 1'b0) begin bad++; $display("FAIL short_early got %b want 0", bus.short_error); end
    set_lv(3'b000);
    tick();
    total++;
    if (bus.short_error !== 1'b1 || bus.short_fault !== 1'b1 || bus.vec_valid !== 1'b0) begin
      bad++; $display("FAIL short_hit got err=%b fault=%b valid=%b want 1/1/0", bus.short_error, bus.short_fault, bus.vec_valid);
    end
    tick();
    total++;
    if (bus.short_error !== 1'b0 || bus.vec_valid !== 1'b1) begin
      bad++; $display("FAIL short_after got err=%b valid=%b want 0/1", bus.short_error, bus.vec_valid);
    end
    hold_lv(3'b000, 10);
    total++;
    if (bus.short_fault !== 1'b1) begin bad++; $display("FAIL short_sticky got %b want 1", bus.short_fault); end
    do_reset();
    total++;
    if (bus.short_fault !== 1'b0) begin bad++; $display("FAIL short_reset got %b want 0", bus.short_fault); end
  endtask

  task automatic test_dead_time();
    logic exp_dead;
`ifdef AC_MOTOR_GATE_DECODER_DEADTIME_CHECK_EN
    exp_dead = 1'b1;
`else
    exp_dead = 1'b0;
`endif
    bus.min_delay = 8'd8;
    do_reset();
    hold_lv(3'b100, 3);
    bus.s1_high = 1'b0; bus.s1_low = 1'b0;
    repeat (7) tick();
    total++;
    if (bus.dead_error !== 1'b0) begin bad++; $display("FAIL dead7_early got %b want 0", bus.dead_error); end
    hold_lv(3'b000, 3);
    total++;
    if (bus.dead_error !== exp_dead) begin bad++; $display("FAIL dead7 got %b want %b", bus.dead_error, exp_dead); end
    do_reset();
    hold_lv(3'b100, 3);
    bus.s1_high = 1'b0; bus.s1_low = 1'b0;
    repeat (2) tick();
    hold_lv(3'b100, 3);
    bus.s1_high = 1'b0; bus.s1_low = 1'b0;
    repeat (8) tick();
    hold_lv(3'b000, 3);
    total++;
    if (bus.dead_error !== 1'b0) begin bad++; $display("FAIL dead8 got %b want 0", bus.dead_error); end
    do_reset();
    hold_lv(3'b100, 3);
    hold_lv(3'b000, 3);
    total++;
    if (bus.dead_error !== exp_dead) begin bad++; $display("FAIL dead_flip got %b want %b", bus.dead_error, exp_dead); end
  endtask

  task automatic test_sector_hold();
    do_reset();
    hold_lv(3'b000, 10);
    hold_lv(3'b011, 10);
    hold_lv(3'b001, 10);
    hold_lv(3'b000, 5);
    total++;
    if (bus.sector !== 3'd3 || bus.sector_valid !== 1'b1) begin
      bad++; $display("FAIL sector3 got %0d/%b want 3/1", bus.sector, bus.sector_valid);
    end
    total++;
    if (bus.t_zero !== 15'd10 || bus.t_first !== 15'd10 || bus.t_second !== 15'd10) begin
      bad++; $display("FAIL sector3_dwell got %0d/%0d/%0d want 10/10/10", bus.t_zero, bus.t_first, bus.t_second);
    end
    hold_lv(3'b100, 10);
    hold_lv(3'b011, 10);
    hold_lv(3'b000, 5);
    total++;
    if (bus.sector !== 3'd3 || bus.sector_valid !== 1'b0) begin
      bad++; $display("FAIL sector_hold got %0d/%b want 3/0", bus.sector, bus.sector_valid);
    end
    total++;
    if (bus.t_zero !== 15'd5 || bus.t_first !== 15'd10 || bus.t_second !== 15'd10) begin
      bad++; $display("FAIL sector_hold_dwell got %0d/%0d/%0d want 5/10/10", bus.t_zero, bus.t_first, bus.t_second);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold_lv(3'b000, 5);
    hold_lv(3'b100, 50);
    do_reset();
    hold_lv(3'b000, 3);
    hold_lv(3'b110, 7);
    hold_lv(3'b111, 2);
    hold_lv(3'b000, 5);
    total++;
    if (bus.t_zero !== 15'd5 || bus.t_first !== 15'd7 || bus.t_second !== 15'd0) begin
      bad++; $display("FAIL reset_mid_dwell got %0d/%0d/%0d want 5/7/0", bus.t_zero, bus.t_first, bus.t_second);
    end
    total++;
    if (bus.sector_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_valid got %b want 0", bus.sector_valid); end
  endtask

  task automatic test_enable();
    int strobes = 0;
    do_reset();
    hold_lv(3'b000, 5);
    hold_lv(3'b100, 10);
    bus.enable = 1'b0;
    set_lv(3'b000);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.cycle_strobe || bus.rev_strobe) strobes++;
    end
    bus.enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.cycle_strobe || bus.rev_strobe) strobes++;
    end
    total++;
    if (strobes !== 0) begin bad++; $display("FAIL enable_off_strobes got %0d want 0", strobes); end
    hold_lv(3'b110, 5);
    hold_lv(3'b000, 5);
    total++;
    if (bus.t_first !== 15'd5 || bus.t_second !== 15'd0) begin
      bad++; $display("FAIL enable_resume got %0d/%0d want 5/0", bus.t_first, bus.t_second);
    end
  endtask

  initial begin
    bus.enable    = 1'b1;
    bus.min_delay = 8'd8;
    set_lv(3'b000);
    test_reset();
    test_vec_decode();
    test_dwell();
    test_revolution();
    test_short();
    test_dead_time();
    test_sector_hold();
    test_reset_mid();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
